mem_bus_arbiter: RTL and testbench

//  N-channel successor to the two-port (I/D) memory bus controller: arbitrates NUM_CH cache-side

---
 rtl/mem_bus_pkg.sv | 31 +++
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter_rr_arbiter.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 107 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and helpers for the memory bus arbiter
package mem_bus_pkg;

  localparam int PTR_W     = 3;
  localparam int MB_ADDR_W = 32;
  localparam int MB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MB_ADDR_W-1:0] addr;
    logic                 wen;
    logic [MB_DATA_W-1:0] wdata;
  } mem_bus_req_t;

  typedef struct packed {
    logic                 valid;
    logic [MB_DATA_W-1:0] rdata;
  } mem_bus_resp_t;

  // Round-robin pointer following a grant, wrapping at the channel count.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g, input int num_ch);
    if (int'(g) + 1 >= num_ch) return '0;
    return g + PTR_W'(1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - channel and memory side signals of the arbiter
interface mem_bus_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0]        req_wen;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     mem_req_ready;
  logic                     mem_req_valid;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic                     mem_req_wen;
  logic [DATA_W-1:0]        mem_req_wdata;
  logic                     mem_resp_valid;
  logic [DATA_W-1:0]        mem_resp_rdata;
  logic                     stray_resp;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, stray_resp
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, stray_resp
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// rtl/mem_bus_arbiter_rr_arbiter.sv - combinational grant selection, fixed or round-robin
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter bit RR_MODE = 1'b1
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic found;
  int   tgt;

  // Visit channels in priority order; fixed mode always starts the scan at channel 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    tgt     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE) tgt = int'(ptr) + k;
      else         tgt = k;
      if (tgt >= NUM_CH) tgt = tgt - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && tgt == j && valid[j]) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = PTR_W'(j);
        end
      end
    end
  end

  assign gnt_any = |valid;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - arbitrates NUM_CH bus masters onto one memory port,
// one outstanding transaction, response routed back to the owning channel.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit RR_MODE    = 1'b1,
  parameter bit WRITE_RESP = 1'b1
) (
  input logic            clk,
  input logic            reset,
  mem_bus_arbiter_if.slave bus
);

  arb_state_t        state, state_n;
  logic [PTR_W-1:0]  rr_ptr, owner, gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic              gnt_any;
  logic [ADDR_W-1:0] lat_addr, sel_addr;
  logic              lat_wen, sel_wen;
  logic [DATA_W-1:0] lat_wdata, sel_wdata;
  logic              stray_q;

  rr_arbiter #(.NUM_CH(NUM_CH), .RR_MODE(RR_MODE)) u_arb (
    .valid   (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        sel_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
        sel_wen   = bus.req_wen[k];
        sel_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_any) state_n = ISSUE;
      ISSUE:   if (bus.mem_req_ready) state_n = (lat_wen && !WRITE_RESP) ? IDLE : WAIT;
      WAIT:    if (bus.mem_resp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      stray_q   <= 1'b0;
    end else begin
      if (state == IDLE && gnt_any) begin
        lat_addr  <= sel_addr;
        lat_wen   <= sel_wen;
        lat_wdata <= sel_wdata;
        owner     <= gnt_idx;
        rr_ptr    <= ptr_after(gnt_idx, NUM_CH);
      end
      // Any response outside WAIT has no owner; it is dropped and flagged until reset.
      if (state != WAIT && bus.mem_resp_valid) stray_q <= 1'b1;
    end
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.resp_valid    = '0;
    bus.resp_rdata    = '0;
    bus.mem_req_valid = !reset && (state == ISSUE);
    if (!reset) begin
      case (state)
        IDLE:  bus.req_ready = gnt;
        ISSUE: if (bus.mem_req_ready && lat_wen && !WRITE_RESP)
                 bus.resp_valid = NUM_CH'(1) << owner;
        WAIT:  if (bus.mem_resp_valid) begin
                 bus.resp_valid = NUM_CH'(1) << owner;
                 bus.resp_rdata = bus.mem_resp_rdata;
               end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_addr  = lat_addr;
  assign bus.mem_req_wen   = lat_wen;
  assign bus.mem_req_wdata = lat_wdata;
  assign bus.stray_resp    = stray_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter, one round-robin
// (WRITE_RESP=1) and one fixed-priority (WRITE_RESP=0) instance sharing stimulus.
module tb_mem_bus_arbiter;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NCH-1:0]    req_valid, req_wen;
  logic [NCH*32-1:0] req_addr, req_wdata;
  logic              mem_req_ready, mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic [31:0]       mem_model [0:255];
  int                errors = 0;
  int                checks = 0;

  mem_bus_arbiter_if #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32)) bus_rr ();
  mem_bus_arbiter_if #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32)) bus_fp ();

  assign bus_rr.req_valid      = req_valid;
  assign bus_rr.req_addr       = req_addr;
  assign bus_rr.req_wen        = req_wen;
  assign bus_rr.req_wdata      = req_wdata;
  assign bus_rr.mem_req_ready  = mem_req_ready;
  assign bus_rr.mem_resp_valid = mem_resp_valid;
  assign bus_rr.mem_resp_rdata = mem_resp_rdata;
  assign bus_fp.req_valid      = req_valid;
  assign bus_fp.req_addr       = req_addr;
  assign bus_fp.req_wen        = req_wen;
  assign bus_fp.req_wdata      = req_wdata;
  assign bus_fp.mem_req_ready  = mem_req_ready;
  assign bus_fp.mem_resp_valid = mem_resp_valid;
  assign bus_fp.mem_resp_rdata = mem_resp_rdata;

  mem_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1), .WRITE_RESP(1'b1))
    dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  mem_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b0), .WRITE_RESP(1'b0))
    dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid      = '0;
    req_wen        = '0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
    req_addr[ch*32 +: 32]  = addr;
    req_wen[ch]            = wen;
    req_wdata[ch*32 +: 32] = wdata;
  endtask

  // One read transaction with zero memory wait states; returns what both DUTs showed.
  task automatic serve(input logic [31:0] rdata,
                       output logic [3:0] g_rr, output logic [3:0] g_fp,
                       output logic [31:0] a_rr, output logic [31:0] a_fp,
                       output logic [3:0] r_rr, output logic [31:0] d_rr);
    #1;
    g_rr = bus_rr.req_ready;
    g_fp = bus_fp.req_ready;
    tick();
    mem_req_ready = 1'b1;
    #1;
    a_rr = bus_rr.mem_req_addr;
    a_fp = bus_fp.mem_req_addr;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    #1;
    r_rr = bus_rr.resp_valid;
    d_rr = bus_rr.resp_rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset     = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    checks++;
    if (bus_rr.req_ready !== 4'b0000 || bus_fp.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ready: got rr=%b fp=%b expected 0000", bus_rr.req_ready, bus_fp.req_ready);
    end
    checks++;
    if (bus_rr.mem_req_valid !== 1'b0 || bus_rr.mem_req_addr !== 32'h0 || bus_rr.mem_req_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_req: got valid=%b addr=%h wen=%b expected 0", bus_rr.mem_req_valid, bus_rr.mem_req_addr, bus_rr.mem_req_wen);
    end
    checks++;
    if (bus_rr.resp_valid !== 4'b0000 || bus_rr.resp_rdata !== 32'h0 || bus_rr.stray_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%b rdata=%h stray=%b expected 0", bus_rr.resp_valid, bus_rr.resp_rdata, bus_rr.stray_resp);
    end
    req_valid = '0;
    reset     = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_ch(0, 32'h100, 1'b0, 32'h0);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (bus_rr.req_ready !== 4'b0001 || bus_rr.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: got ready=%b mem_valid=%b expected 0001/0", bus_rr.req_ready, bus_rr.mem_req_valid);
    end
    tick();
    req_valid     = '0;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus_rr.mem_req_valid !== 1'b1 || bus_rr.mem_req_addr !== 32'h100 || bus_rr.mem_req_wen !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: got valid=%b addr=%h wen=%b expected 1/00000100/0", bus_rr.mem_req_valid, bus_rr.mem_req_addr, bus_rr.mem_req_wen);
    end
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus_rr.resp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL read_wait_%0d: got resp_valid=%b expected 0000", i, bus_rr.resp_valid);
      end
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = mem_model[8'h40];
    #1;
    checks++;
    if (bus_rr.resp_valid !== 4'b0001 || bus_rr.resp_rdata !== 32'hA5000040) begin
      errors++;
      $display("FAIL read_resp: got valid=%b rdata=%h expected 0001/a5000040", bus_rr.resp_valid, bus_rr.resp_rdata);
    end
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #1;
    checks++;
    if (bus_rr.resp_valid !== 4'b0000 || bus_rr.resp_rdata !== 32'h0 || bus_rr.stray_resp !== 1'b0) begin
      errors++;
      $display("FAIL read_after: got valid=%b rdata=%h stray=%b expected 0", bus_rr.resp_valid, bus_rr.resp_rdata, bus_rr.stray_resp);
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0]  g_rr, g_fp, r_rr, exp;
    logic [31:0] a_rr, a_fp, d_rr;
    int          ch;
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 32'h200 + 32'(c * 4), 1'b0, 32'h0);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      ch  = i % NCH;
      exp = 4'b0001 << ch;
      serve(32'hC0DE0000 + 32'(i), g_rr, g_fp, a_rr, a_fp, r_rr, d_rr);
      checks++;
      if (g_rr !== exp) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b expected %b", i, g_rr, exp);
      end
      checks++;
      if (a_rr !== 32'h200 + 32'(ch * 4)) begin
        errors++;
        $display("FAIL rr_addr_%0d: got %h expected %h", i, a_rr, 32'h200 + 32'(ch * 4));
      end
      checks++;
      if (r_rr !== exp || d_rr !== 32'hC0DE0000 + 32'(i)) begin
        errors++;
        $display("FAIL rr_resp_%0d: got %b/%h expected %b/%h", i, r_rr, d_rr, exp, 32'hC0DE0000 + 32'(i));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_fixed_priority();
    logic [3:0]  g_rr, g_fp, r_rr;
    logic [31:0] a_rr, a_fp, d_rr;
    do_reset();
    set_ch(1, 32'h300, 1'b0, 32'h0);
    set_ch(3, 32'h30C, 1'b0, 32'h0);
    req_valid = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      serve(32'h0, g_rr, g_fp, a_rr, a_fp, r_rr, d_rr);
      checks++;
      if (g_fp !== 4'b0010 || a_fp !== 32'h300) begin
        errors++;
        $display("FAIL fp_hold_%0d: got %b/%h expected 0010/00000300", i, g_fp, a_fp);
      end
      checks++;
      if (g_rr !== (i == 0 ? 4'b0010 : 4'b1000)) begin
        errors++;
        $display("FAIL fp_rr_alt_%0d: got %b expected %b", i, g_rr, (i == 0 ? 4'b0010 : 4'b1000));
      end
    end
    req_valid = 4'b1000;
    serve(32'h0, g_rr, g_fp, a_rr, a_fp, r_rr, d_rr);
    checks++;
    if (g_fp !== 4'b1000 || a_fp !== 32'h30C) begin
      errors++;
      $display("FAIL fp_after_drop: got %b/%h expected 1000/0000030c", g_fp, a_fp);
    end
    req_valid = '0;
  endtask

  task automatic test_write_noresp();
    do_reset();
    set_ch(2, 32'h40, 1'b1, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (bus_fp.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wr_grant: got %b expected 0100", bus_fp.req_ready);
    end
    tick();
    req_valid = 4'b0001;
    set_ch(0, 32'h40, 1'b0, 32'h0);
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus_fp.mem_req_valid !== 1'b1 || bus_fp.mem_req_wen !== 1'b1 || bus_fp.mem_req_addr !== 32'h40 || bus_fp.mem_req_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_issue: got v=%b wen=%b addr=%h data=%h expected 1/1/00000040/deadbeef",
               bus_fp.mem_req_valid, bus_fp.mem_req_wen, bus_fp.mem_req_addr, bus_fp.mem_req_wdata);
    end
    checks++;
    if (bus_fp.resp_valid !== 4'b0100 || bus_fp.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_accept_resp: got %b/%h expected 0100/00000000", bus_fp.resp_valid, bus_fp.resp_rdata);
    end
    mem_model[bus_fp.mem_req_addr[9:2]] = bus_fp.mem_req_wdata;
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (bus_fp.req_ready !== 4'b0001 || bus_fp.resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL wr_idle_next: got ready=%b resp=%b expected 0001/0000", bus_fp.req_ready, bus_fp.resp_valid);
    end
    tick();
    req_valid     = '0;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus_fp.mem_req_valid !== 1'b1 || bus_fp.mem_req_wen !== 1'b0 || bus_fp.mem_req_addr !== 32'h40) begin
      errors++;
      $display("FAIL rb_issue: got v=%b wen=%b addr=%h expected 1/0/00000040", bus_fp.mem_req_valid, bus_fp.mem_req_wen, bus_fp.mem_req_addr);
    end
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = mem_model[8'h10];
    #1;
    checks++;
    if (bus_fp.resp_valid !== 4'b0001 || bus_fp.resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rb_resp: got %b/%h expected 0001/deadbeef", bus_fp.resp_valid, bus_fp.resp_rdata);
    end
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h5555AAAA;
    #1;
    checks++;
    if (bus_fp.resp_valid !== 4'b0000 || bus_fp.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rb_rdata_zero: got %b/%h expected 0000/00000000", bus_fp.resp_valid, bus_fp.resp_rdata);
    end
    mem_resp_rdata = '0;
  endtask

  task automatic test_issue_stall();
    do_reset();
    set_ch(1, 32'h80, 1'b1, 32'h12345678);
    set_ch(3, 32'h8C, 1'b0, 32'h0);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (bus_rr.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_grant: got %b expected 0010", bus_rr.req_ready);
    end
    tick();
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus_rr.mem_req_valid !== 1'b1 || bus_rr.mem_req_addr !== 32'h80 || bus_rr.mem_req_wen !== 1'b1 ||
          bus_rr.mem_req_wdata !== 32'h12345678 || bus_rr.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b addr=%h wen=%b data=%h ready=%b expected 1/00000080/1/12345678/0000",
                 i, bus_rr.mem_req_valid, bus_rr.mem_req_addr, bus_rr.mem_req_wen, bus_rr.mem_req_wdata, bus_rr.req_ready);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    checks++;
    if (bus_rr.resp_valid !== 4'b0010 || bus_rr.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL stall_write_resp: got resp=%b ready=%b expected 0010/0000", bus_rr.resp_valid, bus_rr.req_ready);
    end
    tick();
    mem_resp_valid = 1'b0;
    req_valid      = '0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    set_ch(0, 32'h100, 1'b0, 32'h0);
    req_valid = 4'b0001;
    tick();
    req_valid     = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (bus_rr.stray_resp !== 1'b0 || bus_rr.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre: got stray=%b mem_valid=%b expected 0/0", bus_rr.stray_resp, bus_rr.mem_req_valid);
    end
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h00000BAD;
    #1;
    checks++;
    if (bus_rr.resp_valid !== 4'b0000 || bus_rr.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_resp: got %b/%h expected 0000/00000000", bus_rr.resp_valid, bus_rr.resp_rdata);
    end
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #1;
    checks++;
    if (bus_rr.stray_resp !== 1'b1 || bus_rr.resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_wait_stray: got stray=%b resp=%b expected 1/0000", bus_rr.stray_resp, bus_rr.resp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'hA5000000 | 32'(i);
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_rr_wrap();
    test_fixed_priority();
    test_write_noresp();
    test_issue_stall();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
